// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ldm_stm_sequencer
// Description : Walks an LDM/STM register list, one memory word per register,
//               and drives register-bank / PC writes plus base writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module ldm_stm_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              is_load_i,
    input  logic              pre_i,
    input  logic              up_i,
    input  logic              wback_i,
    input  logic [3:0]        base_reg_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [15:0]       reg_list_i,
    output logic [4:0]        bank_raddr_o,
    input  logic [DATA_W-1:0] bank_rdata_i,
    output logic [4:0]        bank_waddr_o,
    output logic [DATA_W-1:0] bank_wdata_o,
    output logic              bank_we_o,
    output logic [DATA_W-1:0] pc_wdata_o,
    output logic              pc_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_req_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_REQ   = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [3:0] lowest_set(input logic [15:0] l);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (l[i]) lowest_set = i[3:0];
        end
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] l);
        popcount16 = 5'd0;
        for (int i = 0; i < 16; i++) begin
            popcount16 = popcount16 + {4'd0, l[i]};
        end
    endfunction

    state_t            state_q;
    logic [15:0]       list_q;
    logic [3:0]        cur_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] final_q;
    logic [3:0]        base_reg_q;
    logic              is_load_q;
    logic              wback_q;
    logic              base_in_list_q;
    logic [4:0]        bank_raddr_q;
    logic [4:0]        bank_waddr_q;
    logic [DATA_W-1:0] bank_wdata_q;
    logic              bank_we_q;
    logic [DATA_W-1:0] pc_wdata_q;
    logic              pc_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              mem_req_q;
    logic              busy_q;
    logic              done_q;

    logic [4:0]        n_d;
    logic [ADDR_W-1:0] four_n_d;
    logic [ADDR_W-1:0] start_addr_d;
    logic [ADDR_W-1:0] final_addr_d;
    logic [15:0]       rem_d;
    logic [3:0]        first_d;
    logic [3:0]        next_d;

    assign n_d      = popcount16(reg_list_i);
    assign four_n_d = ADDR_W'({n_d, 2'b00});
    assign first_d  = lowest_set(reg_list_i);
    assign rem_d    = list_q & ~(16'h0001 << cur_q);
    assign next_d   = lowest_set(rem_d);

    // Every mode walks upward; only the starting point differs.
    always_comb begin
        start_addr_d = base_addr_i;
        case ({pre_i, up_i})
            2'b01:   start_addr_d = base_addr_i;
            2'b11:   start_addr_d = base_addr_i + ADDR_W'(4);
            2'b00:   start_addr_d = base_addr_i - four_n_d + ADDR_W'(4);
            default: start_addr_d = base_addr_i - four_n_d;
        endcase
        final_addr_d = up_i ? (base_addr_i + four_n_d) : (base_addr_i - four_n_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            list_q         <= '0;
            cur_q          <= '0;
            addr_q         <= '0;
            final_q        <= '0;
            base_reg_q     <= '0;
            is_load_q      <= 1'b0;
            wback_q        <= 1'b0;
            base_in_list_q <= 1'b0;
            bank_raddr_q   <= '0;
            bank_waddr_q   <= '0;
            bank_wdata_q   <= '0;
            bank_we_q      <= 1'b0;
            pc_wdata_q     <= '0;
            pc_we_q        <= 1'b0;
            mem_wdata_q    <= '0;
            mem_we_q       <= 1'b0;
            mem_req_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            bank_we_q <= 1'b0;
            pc_we_q   <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        is_load_q      <= is_load_i;
                        wback_q        <= wback_i;
                        base_reg_q     <= base_reg_i;
                        base_in_list_q <= reg_list_i[base_reg_i];
                        list_q         <= reg_list_i;
                        addr_q         <= start_addr_d;
                        final_q        <= final_addr_d;
                        cur_q          <= first_d;
                        bank_raddr_q   <= {1'b0, first_d};
                        busy_q         <= 1'b1;
                        state_q        <= (reg_list_i == 16'h0000) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!is_load_q) mem_wdata_q <= bank_rdata_i;
                    mem_we_q  <= !is_load_q;
                    mem_req_q <= 1'b1;
                    state_q   <= S_REQ;
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        addr_q       <= addr_q + ADDR_W'(4);
                        list_q       <= rem_d;
                        cur_q        <= next_d;
                        bank_raddr_q <= {1'b0, next_d};
                        if (is_load_q) begin
                            if (cur_q == 4'd15) begin
                                pc_we_q    <= 1'b1;
                                pc_wdata_q <= {mem_rdata_i[DATA_W-1:2], 2'b00};
                            end else begin
                                bank_we_q    <= 1'b1;
                                bank_waddr_q <= {1'b0, cur_q};
                                bank_wdata_q <= mem_rdata_i;
                            end
                        end
                        if (rem_d != 16'h0000)
                            state_q <= S_FETCH;
                        else if (wback_q && !(is_load_q && base_in_list_q))
                            state_q <= S_WB;
                        else
                            state_q <= S_DONE;
                    end
                end
                // The strobe lands one cycle after WB, clear of the last load write.
                S_WB: begin
                    bank_we_q    <= 1'b1;
                    bank_waddr_q <= {1'b0, base_reg_q};
                    bank_wdata_q <= DATA_W'(final_q);
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bank_raddr_o = bank_raddr_q;
    assign bank_waddr_o = bank_waddr_q;
    assign bank_wdata_o = bank_wdata_q;
    assign bank_we_o    = bank_we_q;
    assign pc_wdata_o   = pc_wdata_q;
    assign pc_we_o      = pc_we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_we_o     = mem_we_q;
    assign mem_req_o    = mem_req_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldm_stm_sequencer
// Description : Directed, table-driven checks of ldm_stm_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        is_load_i = 1'b0;
    logic        pre_i = 1'b0;
    logic        up_i = 1'b0;
    logic        wback_i = 1'b0;
    logic [3:0]  base_reg_i = '0;
    logic [31:0] base_addr_i = '0;
    logic [15:0] reg_list_i = '0;
    logic [4:0]  bank_raddr_o;
    logic [31:0] bank_rdata_i;
    logic [4:0]  bank_waddr_o;
    logic [31:0] bank_wdata_o;
    logic        bank_we_o;
    logic [31:0] pc_wdata_o;
    logic        pc_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_we_o;
    logic        mem_req_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        busy_o;
    logic        done_o;

    logic [31:0] rf [16];

    always #5 clk = ~clk;

    // Bank read model: data valid in the same cycle as the address.
    assign bank_rdata_i = rf[bank_raddr_o[3:0]];

    ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .is_load_i    (is_load_i),
        .pre_i        (pre_i),
        .up_i         (up_i),
        .wback_i      (wback_i),
        .base_reg_i   (base_reg_i),
        .base_addr_i  (base_addr_i),
        .reg_list_i   (reg_list_i),
        .bank_raddr_o (bank_raddr_o),
        .bank_rdata_i (bank_rdata_i),
        .bank_waddr_o (bank_waddr_o),
        .bank_wdata_o (bank_wdata_o),
        .bank_we_o    (bank_we_o),
        .pc_wdata_o   (pc_wdata_o),
        .pc_we_o      (pc_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_we_o     (mem_we_o),
        .mem_req_o    (mem_req_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] txn_addr [$];
    logic [31:0] txn_data [$];
    logic [31:0] txn_we   [$];
    logic [31:0] bw_addr  [$];
    logic [31:0] bw_data  [$];
    logic [31:0] pc_data  [$];
    logic [31:0] rdq      [$];
    int          done_cnt;
    int          done_cyc;
    int          stable_bad;
    int          first_req_cycles;
    logic        busy1;

    typedef struct {
        logic        pre;
        logic        up;
        logic [31:0] base;
        logic [15:0] list;
        logic [31:0] exp_first;
        logic [31:0] exp_final;
        int          exp_n;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q [$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic do_op(input logic ld, input logic pre, input logic up, input logic wb,
                         input logic [3:0] breg, input logic [31:0] base,
                         input logic [15:0] list, input int stall);
        int          req_cnt;
        logic [31:0] held_addr;
        logic [31:0] held_wdata;
        txn_addr.delete(); txn_data.delete(); txn_we.delete();
        bw_addr.delete(); bw_data.delete(); pc_data.delete();
        done_cnt = 0; done_cyc = -1; stable_bad = 0; first_req_cycles = 0;
        busy1 = 1'b0; req_cnt = 0; held_addr = '0; held_wdata = '0;
        @(negedge clk);
        is_load_i = ld; pre_i = pre; up_i = up; wback_i = wb;
        base_reg_i = breg; base_addr_i = base; reg_list_i = list; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 1; cyc < 300; cyc++) begin
            if (cyc == 1) busy1 = busy_o;
            if (bank_we_o) begin
                bw_addr.push_back({27'd0, bank_waddr_o});
                bw_data.push_back(bank_wdata_o);
            end
            if (pc_we_o) pc_data.push_back(pc_wdata_o);
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            mem_ack_i = 1'b0;
            if (mem_req_o) begin
                if (req_cnt == 0) begin
                    held_addr = mem_addr_o; held_wdata = mem_wdata_o;
                end else if (mem_addr_o !== held_addr || mem_wdata_o !== held_wdata) begin
                    stable_bad++;
                end
                if (txn_addr.size() == 0) first_req_cycles++;
                if (req_cnt == stall) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
                    txn_addr.push_back(mem_addr_o);
                    txn_data.push_back(mem_wdata_o);
                    txn_we.push_back({31'd0, mem_we_o});
                    req_cnt = 0;
                end else begin
                    req_cnt++;
                end
            end
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
        end
        mem_ack_i = 1'b0;
        chk("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
    endtask

    task automatic check_test1(input string tag);
        chk({tag, "_ntxn"}, txn_addr.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), qget(txn_addr, i), 32'h1000 + 32'(4 * i));
            chk($sformatf("%s_data%0d", tag, i), qget(txn_data, i), 32'h11 * 32'(i + 1));
            chk($sformatf("%s_we%0d", tag, i), qget(txn_we, i), 32'd1);
        end
        chk({tag, "_nbw"}, bw_addr.size(), 32'd1);
        chk({tag, "_wb_reg"}, qget(bw_addr, 0), 32'd13);
        chk({tag, "_wb_val"}, qget(bw_data, 0), 32'h100C);
        chk({tag, "_npc"}, pc_data.size(), 32'd0);
        chk({tag, "_done_cnt"}, done_cnt, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy1}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h100 + 32'(i);
        rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33; rf[0] = 32'h55;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 16'h00F0, 32'h0000_0100, 32'h0000_0110, 4};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 16'h0003, 32'h0000_0104, 32'h0000_0108, 2};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0100, 16'h0007, 32'h0000_00F8, 32'h0000_00F4, 3};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0100, 16'h0401, 32'h0000_00F8, 32'h0000_00F8, 2};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0004, 16'h000F, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 4};
        vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 16'h0003, 32'hFFFF_FFFC, 32'h0000_0004, 2};

        #1;
        chk("reset_outs", {8'd0, bank_raddr_o, bank_waddr_o, bank_we_o, pc_we_o, mem_we_o,
                           mem_req_o, busy_o, done_o, 8'd0},
            32'd0);
        chk("reset_data", bank_wdata_o | pc_wdata_o | mem_addr_o | mem_wdata_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // STM IA with writeback
        do_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h1000, 16'h000E, 0);
        check_test1("stm_ia");

        // LDM DB, r15 in the list
        rdq = '{32'hA, 32'hB, 32'h1237};
        do_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 32'h2000, 16'h8003, 0);
        chk("ldm_db_ntxn", txn_addr.size(), 32'd3);
        chk("ldm_db_addr0", qget(txn_addr, 0), 32'h1FF4);
        chk("ldm_db_addr1", qget(txn_addr, 1), 32'h1FF8);
        chk("ldm_db_addr2", qget(txn_addr, 2), 32'h1FFC);
        chk("ldm_db_we", qget(txn_we, 0), 32'd0);
        chk("ldm_db_nbw", bw_addr.size(), 32'd2);
        chk("ldm_db_r0", qget(bw_data, 0), 32'hA);
        chk("ldm_db_r0a", qget(bw_addr, 0), 32'd0);
        chk("ldm_db_r1", qget(bw_data, 1), 32'hB);
        chk("ldm_db_r1a", qget(bw_addr, 1), 32'd1);
        chk("ldm_db_npc", pc_data.size(), 32'd1);
        chk("ldm_db_pc", qget(pc_data, 0), 32'h1234);

        // LDM with base in list: loaded value wins over writeback
        rdq = '{32'hDEAD};
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h4000, 16'h0004, 0);
        chk("ldm_base_nbw", bw_addr.size(), 32'd1);
        chk("ldm_base_reg", qget(bw_addr, 0), 32'd2);
        chk("ldm_base_val", qget(bw_data, 0), 32'hDEAD);

        // Empty list
        do_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h5000, 16'h0000, 0);
        chk("empty_done_cyc", done_cyc, 32'd2);
        chk("empty_ntxn", txn_addr.size(), 32'd0);
        chk("empty_nbw", bw_addr.size(), 32'd0);
        chk("empty_done_cnt", done_cnt, 32'd1);

        // Stalled memory, store then load
        do_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd13, 32'h3000, 16'h0001, 5);
        chk("stall_st_req_cyc", first_req_cycles, 32'd6);
        chk("stall_st_stable", stable_bad, 32'd0);
        chk("stall_st_data", qget(txn_data, 0), 32'h55);
        rdq = '{32'h77};
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 32'h3000, 16'h0010, 5);
        chk("stall_ld_req_cyc", first_req_cycles, 32'd6);
        chk("stall_ld_stable", stable_bad, 32'd0);
        chk("stall_ld_nbw", bw_addr.size(), 32'd1);
        chk("stall_ld_bw", qget(bw_data, 0), 32'h77);
        chk("stall_ld_bwa", qget(bw_addr, 0), 32'd4);

        // Address-mode table (stores with writeback to r13)
        for (int i = 0; i < 6; i++) begin
            int step_bad;
            do_op(1'b0, vecs[i].pre, vecs[i].up, 1'b1, 4'd13, vecs[i].base, vecs[i].list, 0);
            step_bad = 0;
            for (int j = 1; j < txn_addr.size(); j++)
                if (txn_addr[j] !== txn_addr[j-1] + 32'd4) step_bad++;
            chk($sformatf("v%0d_ntxn", i), txn_addr.size(), 32'(vecs[i].exp_n));
            chk($sformatf("v%0d_first", i), qget(txn_addr, 0), vecs[i].exp_first);
            chk($sformatf("v%0d_step", i), step_bad, 32'd0);
            chk($sformatf("v%0d_wb_reg", i), qget(bw_addr, 0), 32'd13);
            chk($sformatf("v%0d_wb_val", i), qget(bw_data, 0), vecs[i].exp_final);
            chk($sformatf("v%0d_done", i), done_cnt, 32'd1);
        end

        // Reset in the middle of a stalled load
        @(negedge clk);
        is_load_i = 1'b1; pre_i = 1'b0; up_i = 1'b1; wback_i = 1'b1;
        base_reg_i = 4'd13; base_addr_i = 32'h6000; reg_list_i = 16'h00FF; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; mem_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_req", {31'd0, mem_req_o}, 32'd1);
        chk("rst_pre_busy", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {28'd0, mem_req_o, bank_we_o, pc_we_o, busy_o}, 32'd0);
        @(negedge clk);
        chk("rst_hold_outs", {28'd0, mem_req_o, bank_we_o, pc_we_o, busy_o}, 32'd0);
        rst_n = 1'b1;

        do_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h1000, 16'h000E, 0);
        check_test1("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
